// File: rtl/slice_receiver_pkg.sv
// Shared definitions for the distributor-to-parser slice hand-off:
// slice field widths, the packed slice record and the receiver FSM encoding.
package slice_receiver_pkg;

  localparam int DATA_W     = 144;
  localparam int POS_W      = 16;
  localparam int ADDR_W     = 17;
  localparam int GARB_W     = 3;
  localparam int SLICE_W    = DATA_W + POS_W + ADDR_W + GARB_W + 1;
  localparam int NUM_PARSER = 6;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [POS_W-1:0]  position;
    logic [ADDR_W-1:0] address;
    logic [GARB_W-1:0] garbage;
    logic              lit_flag;
  } slice_t;

endpackage

// File: rtl/slice_buf_ram.sv
// DEPTH x SLICE_W register array: one synchronous write port and one
// asynchronous read port so the head entry is visible without a read cycle.
module slice_buf_ram
  import slice_receiver_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  slice_t           wdata,
  input  logic [PTR_W-1:0] raddr,
  output slice_t           rdata
);

  slice_t mem_q [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the occupancy count,
  // and leaving the array unreset lets it map to plain flops or RAM.
  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/slice_receiver.sv
// Parser-side receiver: buffers up to DEPTH slices from the distributor, presents
// them in order through valid/ack, and supports a drain-to-empty handshake.
module slice_receiver
  import slice_receiver_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [POS_W-1:0]  position_in,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [GARB_W-1:0] garbage_in,
  input  logic              lit_flag_in,
  output logic              ready,
  input  logic              drain,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [POS_W-1:0]  out_position,
  output logic [ADDR_W-1:0] out_address,
  output logic [GARB_W-1:0] out_garbage,
  output logic              out_lit_flag,
  input  logic              out_ack,
  output logic              drained,
  output logic [CNT_W-1:0]  accept_cnt,
  output logic              overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  rx_state_e        state_q;
  logic             drained_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d;
  logic             overflow_q, overflow_d;

  logic   accept;
  logic   consume;
  slice_t wr_slice;
  slice_t rd_slice;

  // ready depends only on registers: the distributor gates valid with it.
  assign ready     = (state_q == ST_RUN) && (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign accept    = valid_in & ready;
  assign consume   = out_ack & out_valid;

  assign wr_slice = '{
    data:     data_in,
    position: position_in,
    address:  address_in,
    garbage:  garbage_in,
    lit_flag: lit_flag_in
  };

  slice_buf_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata (wr_slice),
    .raddr (rd_ptr_q),
    .rdata (rd_slice)
  );

  assign out_data     = rd_slice.data;
  assign out_position = rd_slice.position;
  assign out_address  = rd_slice.address;
  assign out_garbage  = rd_slice.garbage;
  assign out_lit_flag = rd_slice.lit_flag;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    accept_cnt_d = accept_cnt_q;
    overflow_d   = overflow_q | (valid_in & ~ready);

    if (accept) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      accept_cnt_d = accept_cnt_q + 1'b1;
    end
    if (consume) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({accept, consume})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: reset is synchronous: it is only sampled at the clock edge, so the
  // reset branch lives inside the plain posedge block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      drained_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      accept_cnt_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      accept_cnt_q <= accept_cnt_d;
      overflow_q   <= overflow_d;

      unique case (state_q)
        ST_RUN: begin
          if (drain) begin
            state_q <= ST_DRAIN;
          end
          drained_q <= 1'b0;
        end
        ST_DRAIN: begin
          if (!drain) begin
            state_q   <= ST_RUN;
            drained_q <= 1'b0;
          end else if (count_q == '0 && !consume) begin
            state_q   <= ST_DONE;
            drained_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain) begin
            state_q   <= ST_RUN;
            drained_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign drained      = drained_q;
  assign accept_cnt   = accept_cnt_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_slice_receiver.sv
// Directed self-checking bench for slice_receiver: fill/consume ordering,
// simultaneous accept+consume, overflow, drain handshake and mid-run reset.
module tb_slice_receiver;
  import slice_receiver_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic [POS_W-1:0]  position_in;
  logic [ADDR_W-1:0] address_in;
  logic [GARB_W-1:0] garbage_in;
  logic              lit_flag_in;
  logic              ready;
  logic              drain;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [POS_W-1:0]  out_position;
  logic [ADDR_W-1:0] out_address;
  logic [GARB_W-1:0] out_garbage;
  logic              out_lit_flag;
  logic              out_ack;
  logic              drained;
  logic [CNT_W-1:0]  accept_cnt;
  logic              overflow_err;

  int vectors = 0;
  int errors  = 0;

  slice_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .position_in  (position_in),
    .address_in   (address_in),
    .garbage_in   (garbage_in),
    .lit_flag_in  (lit_flag_in),
    .ready        (ready),
    .drain        (drain),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_position (out_position),
    .out_address  (out_address),
    .out_garbage  (out_garbage),
    .out_lit_flag (out_lit_flag),
    .out_ack      (out_ack),
    .drained      (drained),
    .accept_cnt   (accept_cnt),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slice fields are derived from the address so expectations are easy to recompute.
  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
    return {9{a[15:0] ^ 16'h5A5A}};
  endfunction
  function automatic logic [POS_W-1:0] exp_pos(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h1234;
  endfunction

  task automatic drive_slice(input logic [ADDR_W-1:0] a);
    valid_in    = 1'b1;
    address_in  = a;
    data_in     = exp_data(a);
    position_in = exp_pos(a);
    garbage_in  = a[6:4];
    lit_flag_in = a[4];
  endtask

  task automatic check_head(input string tag, input logic [ADDR_W-1:0] a);
    check({tag, "_addr"}, DATA_W'(out_address), DATA_W'(a));
    check({tag, "_data"}, out_data, exp_data(a));
    check({tag, "_pos"},  DATA_W'(out_position), DATA_W'(exp_pos(a)));
    check({tag, "_garb"}, DATA_W'(out_garbage), DATA_W'(a[6:4]));
    check({tag, "_lit"},  DATA_W'(out_lit_flag), DATA_W'(a[4]));
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; drain = 1'b0; out_ack = 1'b0;
    data_in = '0; position_in = '0; address_in = '0; garbage_in = '0; lit_flag_in = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_ready",    DATA_W'(ready), 1);
    check("rst_valid",    DATA_W'(out_valid), 0);
    check("rst_cnt",      DATA_W'(accept_cnt), 0);
    check("rst_drained",  DATA_W'(drained), 0);
    check("rst_overflow", DATA_W'(overflow_err), 0);

    // Two back-to-back accepts fill the buffer
    drive_slice(17'h00010);
    step();
    check("fill1_ready", DATA_W'(ready), 1);
    check("fill1_valid", DATA_W'(out_valid), 1);
    check_head("fill1", 17'h00010);
    drive_slice(17'h00020);
    step();
    valid_in = 1'b0;
    check("fill2_ready", DATA_W'(ready), 0);
    check("fill2_cnt",   DATA_W'(accept_cnt), 2);
    check_head("fill2", 17'h00010);

    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    check("ack1_ready", DATA_W'(ready), 1);
    check_head("ack1", 17'h00020);

    // Simultaneous accept and consume with one entry buffered
    drive_slice(17'h00030);
    out_ack = 1'b1;
    step();
    valid_in = 1'b0; out_ack = 1'b0;
    check("sim_valid", DATA_W'(out_valid), 1);
    check("sim_ready", DATA_W'(ready), 1);
    check("sim_cnt",   DATA_W'(accept_cnt), 3);
    check_head("sim", 17'h00030);

    // Fill, then force valid_in while full
    drive_slice(17'h00040);
    step();
    check("full_ready", DATA_W'(ready), 0);
    drive_slice(17'h00050);
    step();
    valid_in = 1'b0;
    check("ovf_err",   DATA_W'(overflow_err), 1);
    check("ovf_cnt",   DATA_W'(accept_cnt), 4);
    check("ovf_ready", DATA_W'(ready), 0);
    check_head("ovf_head", 17'h00030);
    out_ack = 1'b1;
    step();
    check_head("ovf_second", 17'h00040);
    step();
    out_ack = 1'b0;
    check("ovf_empty",  DATA_W'(out_valid), 0);
    check("ovf_sticky", DATA_W'(overflow_err), 1);
    check("ovf_ready2", DATA_W'(ready), 1);

    // Ack while empty is ignored
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    check("idle_ack_valid", DATA_W'(out_valid), 0);
    check("idle_ack_ready", DATA_W'(ready), 1);

    // Drain with two entries buffered
    drive_slice(17'h00060);
    step();
    drive_slice(17'h00070);
    step();
    valid_in = 1'b0;
    drain = 1'b1;
    step();
    check("drn_ready",   DATA_W'(ready), 0);
    check("drn_drained", DATA_W'(drained), 0);
    check_head("drn_head", 17'h00060);
    out_ack = 1'b1;
    step();
    check_head("drn_second", 17'h00070);
    check("drn_mid_drained", DATA_W'(drained), 0);
    step();
    out_ack = 1'b0;
    check("drn_empty",       DATA_W'(out_valid), 0);
    check("drn_zero_drained", DATA_W'(drained), 0);
    step();
    check("drn_done",       DATA_W'(drained), 1);
    check("drn_done_ready", DATA_W'(ready), 0);
    drive_slice(17'h000AA);
    step();
    valid_in = 1'b0;
    check("done_reject", DATA_W'(out_valid), 0);
    check("done_cnt",    DATA_W'(accept_cnt), 6);
    drain = 1'b0;
    step();
    check("undrn_drained", DATA_W'(drained), 0);
    check("undrn_ready",   DATA_W'(ready), 1);

    // Dropping drain mid-DRAIN keeps the entry and resumes RUN
    drive_slice(17'h00080);
    step();
    valid_in = 1'b0;
    check("abort_ready0", DATA_W'(ready), 1);
    drain = 1'b1;
    step();
    check("abort_ready1", DATA_W'(ready), 0);
    drain = 1'b0;
    step();
    check("abort_ready2", DATA_W'(ready), 1);
    check("abort_valid",  DATA_W'(out_valid), 1);
    check_head("abort_head", 17'h00080);

    // Reset with two entries buffered and the FSM in DRAIN
    drive_slice(17'h00090);
    step();
    valid_in = 1'b0;
    drain = 1'b1;
    step();
    check("pre_rst_cnt",   DATA_W'(accept_cnt), 8);
    check("pre_rst_ready", DATA_W'(ready), 0);
    rst = 1'b1; drain = 1'b0;
    step();
    rst = 1'b0;
    check("mrst_valid",    DATA_W'(out_valid), 0);
    check("mrst_ready",    DATA_W'(ready), 1);
    check("mrst_overflow", DATA_W'(overflow_err), 0);
    check("mrst_cnt",      DATA_W'(accept_cnt), 0);
    check("mrst_drained",  DATA_W'(drained), 0);

    drive_slice(17'h1ABCD);
    step();
    valid_in = 1'b0;
    check("post_rst_cnt", DATA_W'(accept_cnt), 1);
    check_head("post_rst", 17'h1ABCD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
